// File: rtl/sync_filter_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter_edge
//  Purpose  : Multi-bit asynchronous input synchroniser with per-bit
//             stability (glitch) filter and registered rise/fall strobes.
//             Every bit is handled independently; a new synchronised level
//             must persist FILTER_CYCLES cycles before it reaches `out`.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_filter_edge #(
    parameter int               WIDTH         = 2,
    parameter int               SYNC_STAGES   = 3,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_async,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter only has to reach FILTER_CYCLES-1; a 1-bit counter is kept
    // even when no filtering is requested so the datapath stays uniform.
    localparam int                 c_CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0]   r_stage [SYNC_STAGES];
    logic [c_CNT_W-1:0] r_cnt   [WIDTH];
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic               r_changed;

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   w_accept;

    // Plain flop chain per bit; shifts every cycle, independent of enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_stage[k] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= in_async;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // A bit is accepted when it differs from `out` and has already been
    // seen different for FILTER_CYCLES-1 earlier enabled cycles.
    always_comb begin
        w_sync   = r_stage[SYNC_STAGES-1];
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = enable && (w_sync[i] != r_out[i]) && (r_cnt[i] == c_CNT_MAX);
        end
    end

    // Per-bit stability counters, accepted level and one-cycle strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out     <= RESET_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // w_accept already includes enable, so strobes drop while frozen.
            r_rise    <= w_accept & w_sync;
            r_fall    <= w_accept & ~w_sync;
            r_changed <= |w_accept;
            if (enable) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_sync[i] == r_out[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == c_CNT_MAX) begin
                        r_out[i] <= w_sync[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out     = r_out;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = r_changed;

endmodule
`default_nettype wire
